// File: rtl/seg_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg
//  Shared definitions for the seven-segment display blocks.
//  - seg_t       : segment vector {g,f,e,d,c,b,a}, bit 0 = segment a
//  - SEG_0..SEG_F: active-high glyphs for the sixteen hex digits
//  - SEG_OFF     : all segments dark (active-high)
//  - hex_to_seg  : nibble -> active-high glyph
// Polarity conversion for the board pins is done by the users of this
// package; every constant here is active-high.
// ---------------------------------------------------------------------------
package seg_pkg;

    typedef logic [6:0] seg_t;

    // Width of one displayed digit in the packed input bus.
    localparam int NIBBLE_W = 4;

    //                            gfedcba
    localparam seg_t SEG_0   = 7'b0111111;
    localparam seg_t SEG_1   = 7'b0000110;
    localparam seg_t SEG_2   = 7'b1011011;
    localparam seg_t SEG_3   = 7'b1001111;
    localparam seg_t SEG_4   = 7'b1100110;
    localparam seg_t SEG_5   = 7'b1101101;
    localparam seg_t SEG_6   = 7'b1111101;
    localparam seg_t SEG_7   = 7'b0000111;
    localparam seg_t SEG_8   = 7'b1111111;
    localparam seg_t SEG_9   = 7'b1101111;
    localparam seg_t SEG_A   = 7'b1110111;
    localparam seg_t SEG_B   = 7'b1111100;
    localparam seg_t SEG_C   = 7'b0111001;
    localparam seg_t SEG_D   = 7'b1011110;
    localparam seg_t SEG_E   = 7'b1111001;
    localparam seg_t SEG_F   = 7'b1110001;
    localparam seg_t SEG_OFF = 7'b0000000;

    // Standard hex glyphs; b and d are lower case so they are not
    // confused with 8 and 0 on a seven-segment digit.
    function automatic seg_t hex_to_seg(input logic [3:0] nibble);
        seg_t glyph;
        case (nibble)
            4'h0:    glyph = SEG_0;
            4'h1:    glyph = SEG_1;
            4'h2:    glyph = SEG_2;
            4'h3:    glyph = SEG_3;
            4'h4:    glyph = SEG_4;
            4'h5:    glyph = SEG_5;
            4'h6:    glyph = SEG_6;
            4'h7:    glyph = SEG_7;
            4'h8:    glyph = SEG_8;
            4'h9:    glyph = SEG_9;
            4'hA:    glyph = SEG_A;
            4'hB:    glyph = SEG_B;
            4'hC:    glyph = SEG_C;
            4'hD:    glyph = SEG_D;
            4'hE:    glyph = SEG_E;
            4'hF:    glyph = SEG_F;
            default: glyph = SEG_OFF;
        endcase
        return glyph;
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// ---------------------------------------------------------------------------
// scan_tick_gen
//  Free-running prescaler. Counts every clock and wraps; tick marks the
//  last count of each 2**DIV_BITS period so a consumer can advance state
//  on the same edge the counter returns to zero.
// Ports
//  clk    in   1         system clock
//  clr_n  in   1         asynchronous active-low reset
//  cnt    out  DIV_BITS  current prescaler count (0 after reset)
//  tick   out  1         high while cnt is all ones
// ---------------------------------------------------------------------------
module scan_tick_gen #(
    parameter int DIV_BITS = 18
) (
    input  logic                clk,
    input  logic                clr_n,
    output logic [DIV_BITS-1:0] cnt,
    output logic                tick
);

    // Plain binary up-counter; natural overflow provides the wrap.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_BITS'(1);
        end
    end

    assign tick = &cnt;

endmodule

// File: rtl/seven_seg_scanner.sv
// ---------------------------------------------------------------------------
// seven_seg_scanner
//  Multiplexed seven-segment driver. Scans NUM_DIGITS hex digits onto one
//  shared set of segment lines, one digit slot per 2**DIV_BITS clocks.
//  Inputs are captured into shadow registers once per frame so a display
//  never shows a mix of old and new digits. Supports per-digit blanking
//  and decimal point, leading-zero suppression, PWM brightness and a
//  selectable pin polarity.
// Parameters
//  NUM_DIGITS  digits scanned (1..16, any value)
//  DIV_BITS    prescaler width; slot length = 2**DIV_BITS clocks
//  PWM_BITS    brightness resolution, must be smaller than DIV_BITS
//  ACTIVE_LOW  1: an/out/dp active-low, 0: active-high
// Ports
//  clk          in   1             system clock
//  clr_n        in   1             asynchronous active-low reset
//  in           in   4*NUM_DIGITS  hex nibbles, digit i = in[4i+3:4i]
//  dp_in        in   NUM_DIGITS    decimal point request per digit
//  blank        in   NUM_DIGITS    1 = digit dark
//  lz_en        in   1             suppress leading zeros
//  bright       in   PWM_BITS      brightness, all ones = always on
//  an           out  NUM_DIGITS    digit enables
//  out          out  7             segments {g,f,e,d,c,b,a}
//  dp           out  1             decimal point segment
//  frame_start  out  1             one-cycle pulse when a snapshot is taken
// ---------------------------------------------------------------------------
module seven_seg_scanner
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int DIV_BITS   = 18,
    parameter int PWM_BITS   = 3,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                       clk,
    input  logic                       clr_n,
    input  logic [4*NUM_DIGITS-1:0]    in,
    input  logic [NUM_DIGITS-1:0]      dp_in,
    input  logic [NUM_DIGITS-1:0]      blank,
    input  logic                       lz_en,
    input  logic [PWM_BITS-1:0]        bright,
    output logic [NUM_DIGITS-1:0]      an,
    output logic [6:0]                 out,
    output logic                       dp,
    output logic                       frame_start
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    // XOR mask turning the internal active-high view into pin levels; the
    // same value is the inactive pin level used at reset and in dark slots.
    localparam logic POL = (ACTIVE_LOW != 0);

    logic [DIV_BITS-1:0]   cnt;
    logic                  tick;
    logic [IDX_W-1:0]      idx;
    logic                  frame_tick;

    logic [NIBBLE_W-1:0]   nib_sh [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] dp_sh;
    logic [NUM_DIGITS-1:0] blank_sh;
    logic                  lz_sh;

    logic [NUM_DIGITS-1:0] suppress;
    logic                  zero_run;
    logic                  pwm_on;
    logic                  slot_lit;
    logic [NUM_DIGITS-1:0] an_on;
    seg_t                  seg_on;
    logic                  dp_on;

    scan_tick_gen #(
        .DIV_BITS (DIV_BITS)
    ) u_tick_gen (
        .clk   (clk),
        .clr_n (clr_n),
        .cnt   (cnt),
        .tick  (tick)
    );

    // The last slot of a frame ends on this tick; it is the single point
    // where the digit index wraps and the shadow registers reload.
    assign frame_tick = tick && (idx == LAST_IDX);

    // Digit index advances once per slot and wraps explicitly so that a
    // non-power-of-two digit count never visits an unused index.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            idx <= '0;
        end else if (tick) begin
            if (idx == LAST_IDX) begin
                idx <= '0;
            end else begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

    // Frame snapshot. Blank resets to all ones so nothing lights until the
    // first full frame has been captured; frame_start is high for the one
    // cycle in which the freshly captured values become visible.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                nib_sh[i] <= '0;
            end
            dp_sh       <= '0;
            blank_sh    <= '1;
            lz_sh       <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= frame_tick;
            if (frame_tick) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    nib_sh[i] <= in[NIBBLE_W*i +: NIBBLE_W];
                end
                dp_sh    <= dp_in;
                blank_sh <= blank;
                lz_sh    <= lz_en;
            end
        end
    end

    // Leading-zero suppression: walk down from the most significant digit
    // and keep suppressing while every digit seen so far is zero. Digit 0
    // is never part of the walk so a value of zero still shows "0".
    always_comb begin
        suppress = '0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run    = zero_run && (nib_sh[i] == 4'h0);
            suppress[i] = lz_sh && zero_run;
        end
    end

    // Comparing the whole count against {bright, all ones} is the same as
    // comparing the top PWM_BITS of cnt against bright, and it makes the
    // all-ones brightness setting always on.
    assign pwm_on = (cnt <= {bright, {(DIV_BITS - PWM_BITS){1'b1}}});

    assign slot_lit = !blank_sh[idx] && !suppress[idx] && pwm_on;

    // Active-high view of the next output state: at most one enable bit,
    // and segments/dp only while the slot is lit.
    always_comb begin
        an_on  = '0;
        seg_on = SEG_OFF;
        dp_on  = 1'b0;
        if (slot_lit) begin
            an_on[idx] = 1'b1;
            seg_on     = hex_to_seg(nib_sh[idx]);
            dp_on      = dp_sh[idx];
        end
    end

    // Registered pins. Reset drives the inactive level directly, so an
    // asynchronous reset can never pass through an active level.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            an  <= {NUM_DIGITS{POL}};
            out <= {7{POL}};
            dp  <= POL;
        end else begin
            an  <= an_on ^ {NUM_DIGITS{POL}};
            out <= seg_on ^ {7{POL}};
            dp  <= dp_on ^ POL;
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// ---------------------------------------------------------------------------
// tb_seven_seg_scanner
//  Bench for seven_seg_scanner with NUM_DIGITS=6, DIV_BITS=4, PWM_BITS=2,
//  active-low pins. A reference model derives every expected pin value from
//  the number of clocks since reset, and a vector table plus a few
//  hand-written sequences target specific glyphs, timing and corner cases.
// ---------------------------------------------------------------------------
module tb_seven_seg_scanner;

    localparam int N  = 6;
    localparam int DB = 4;
    localparam int PB = 2;
    localparam int AL = 1;

    localparam int SLOT_CLKS  = 1 << DB;
    localparam int FRAME_CLKS = SLOT_CLKS * N;

    logic          clk = 1'b0;
    logic          clr_n = 1'b0;
    logic [4*N-1:0] in;
    logic [N-1:0]  dp_in;
    logic [N-1:0]  blank;
    logic          lz_en;
    logic [PB-1:0] bright;
    logic [N-1:0]  an;
    logic [6:0]    out;
    logic          dp;
    logic          frame_start;

    int checks = 0;
    int errors = 0;

    seven_seg_scanner #(
        .NUM_DIGITS (N),
        .DIV_BITS   (DB),
        .PWM_BITS   (PB),
        .ACTIVE_LOW (AL)
    ) dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .in          (in),
        .dp_in       (dp_in),
        .blank       (blank),
        .lz_en       (lz_en),
        .bright      (bright),
        .an          (an),
        .out         (out),
        .dp          (dp),
        .frame_start (frame_start)
    );

    // 10 time-unit clock: posedges at 5, 15, ...; negedges at 10, 20, ...
    always #5 clk = ~clk;

    // Safety net in case the design never produces the awaited events.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [23:0] nibs, input logic [5:0] dps,
                                 input logic [5:0] blanks, input logic lz, input logic [1:0] br);
        in     = nibs;
        dp_in  = dps;
        blank  = blanks;
        lz_en  = lz;
        bright = br;
    endtask

    // Waits (bounded) for the next frame_start, sampled on negedges.
    task automatic waitFrame(output int cycles, output bit ok);
        cycles = 0;
        ok     = 1'b0;
        for (int i = 0; i < 3 * FRAME_CLKS; i++) begin
            @(negedge clk);
            cycles++;
            if (frame_start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Moves from a frame_start negedge to the negedge on which the pins show
    // slot s at prescaler count c of the new frame (one clock of latency).
    task automatic gotoSlot(input int s, input int c);
        repeat (1 + SLOT_CLKS * s + c) @(posedge clk);
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Reference model: pin values from elapsed clocks since reset.
    // ------------------------------------------------------------------
    function automatic logic [6:0] glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0: g = 7'h3F; 4'h1: g = 7'h06; 4'h2: g = 7'h5B; 4'h3: g = 7'h4F;
            4'h4: g = 7'h66; 4'h5: g = 7'h6D; 4'h6: g = 7'h7D; 4'h7: g = 7'h07;
            4'h8: g = 7'h7F; 4'h9: g = 7'h6F; 4'hA: g = 7'h77; 4'hB: g = 7'h7C;
            4'hC: g = 7'h39; 4'hD: g = 7'h5E; 4'hE: g = 7'h79; default: g = 7'h71;
        endcase
        return g;
    endfunction

    // kk = number of this rising edge since reset release (1-based); the
    // pins after edge kk describe the state that existed just before it.
    function automatic logic [14:0] modelPins(input int kk, input bit valid, input logic [23:0] nibs,
                                              input logic [5:0] dps, input logic [5:0] blanks,
                                              input logic lz, input logic [1:0] br);
        int c = (kk - 1) % SLOT_CLKS;
        int s = ((kk - 1) / SLOT_CLKS) % N;
        bit lead_zero = lz && (s > 0) && ((nibs >> (4 * s)) == 24'h0);
        bit lit = valid && !blanks[s] && !lead_zero && ((c / (SLOT_CLKS >> PB)) <= int'(br));
        logic [5:0] m_an  = lit ? ~(6'b000001 << s) : 6'h3F;
        logic [6:0] m_out = lit ? ~glyph(nibs[4*s +: 4]) : 7'h7F;
        logic       m_dp  = !(lit && dps[s]);
        logic       m_fs  = (kk % FRAME_CLKS) == 0;
        return {m_an, m_out, m_dp, m_fs};
    endfunction

    int          k = 0;
    bit          sh_valid = 1'b0;
    logic [23:0] m_in = '0;
    logic [5:0]  m_dp = '0;
    logic [5:0]  m_blank = '0;
    logic        m_lz = 1'b0;
    logic [5:0]  exp_an = 6'h3F;
    logic [6:0]  exp_out = 7'h7F;
    logic        exp_dp = 1'b1;
    logic        exp_fs = 1'b0;
    bit          chk_en = 1'b0;

    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            k        <= 0;
            sh_valid <= 1'b0;
            exp_an   <= 6'h3F;
            exp_out  <= 7'h7F;
            exp_dp   <= 1'b1;
            exp_fs   <= 1'b0;
        end else begin
            k <= k + 1;
            {exp_an, exp_out, exp_dp, exp_fs} <= modelPins(k + 1, sh_valid, m_in, m_dp, m_blank, m_lz, bright);
            if ((k + 1) % FRAME_CLKS == 0) begin
                m_in     <= in;
                m_dp     <= dp_in;
                m_blank  <= blank;
                m_lz     <= lz_en;
                sh_valid <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("model_an", 32'(an), 32'(exp_an));
            checkOutput("model_out", 32'(out), 32'(exp_out));
            checkOutput("model_dp", 32'(dp), 32'(exp_dp));
            checkOutput("model_frame_start", 32'(frame_start), 32'(exp_fs));
        end
    end

    // ------------------------------------------------------------------
    // Directed vector table (expected values are active-low pin levels).
    // ------------------------------------------------------------------
    typedef struct {
        logic [23:0] nibs;
        logic [5:0]  dps;
        logic [5:0]  blanks;
        logic        lz;
        logic [1:0]  br;
        int          slot;
        int          cnt;
        logic [5:0]  e_an;
        logic [6:0]  e_out;
        logic        e_dp;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input logic [23:0] nibs, input logic [5:0] dps, input logic [5:0] blanks,
                          input logic lz, input logic [1:0] br, input int slot, input int cnt,
                          input logic [5:0] e_an, input logic [6:0] e_out, input logic e_dp);
        vec_t v;
        v.nibs = nibs; v.dps = dps; v.blanks = blanks; v.lz = lz; v.br = br;
        v.slot = slot; v.cnt = cnt; v.e_an = e_an; v.e_out = e_out; v.e_dp = e_dp;
        vecs.push_back(v);
    endtask

    int   cyc;
    bit   ok;
    bit   saw_lit;

    initial begin
        // plain scan of 123456 at full brightness
        addVec(24'h123456, 6'h00, 6'h00, 1'b0, 2'd3, 0, 0, 6'h3E, 7'h02, 1'b1);
        addVec(24'h123456, 6'h00, 6'h00, 1'b0, 2'd3, 1, 0, 6'h3D, 7'h12, 1'b1);
        addVec(24'h123456, 6'h00, 6'h00, 1'b0, 2'd3, 2, 9, 6'h3B, 7'h19, 1'b1);
        addVec(24'h123456, 6'h00, 6'h00, 1'b0, 2'd3, 3, 15, 6'h37, 7'h30, 1'b1);
        addVec(24'h123456, 6'h00, 6'h00, 1'b0, 2'd3, 4, 0, 6'h2F, 7'h24, 1'b1);
        addVec(24'h123456, 6'h00, 6'h00, 1'b0, 2'd3, 5, 0, 6'h1F, 7'h79, 1'b1);
        // leading-zero suppression
        addVec(24'h000340, 6'h00, 6'h00, 1'b1, 2'd3, 0, 0, 6'h3E, 7'h40, 1'b1);
        addVec(24'h000340, 6'h00, 6'h00, 1'b1, 2'd3, 1, 0, 6'h3D, 7'h19, 1'b1);
        addVec(24'h000340, 6'h00, 6'h00, 1'b1, 2'd3, 2, 0, 6'h3B, 7'h30, 1'b1);
        addVec(24'h000340, 6'h00, 6'h00, 1'b1, 2'd3, 3, 0, 6'h3F, 7'h7F, 1'b1);
        addVec(24'h000340, 6'h00, 6'h00, 1'b1, 2'd3, 5, 0, 6'h3F, 7'h7F, 1'b1);
        addVec(24'h000000, 6'h00, 6'h00, 1'b1, 2'd3, 0, 0, 6'h3E, 7'h40, 1'b1);
        addVec(24'h000000, 6'h00, 6'h00, 1'b1, 2'd3, 1, 0, 6'h3F, 7'h7F, 1'b1);
        addVec(24'h000000, 6'h00, 6'h00, 1'b0, 2'd3, 4, 0, 6'h2F, 7'h40, 1'b1);
        // inner zero below a non-zero digit is shown; glyphs 7, 8, 9, d
        addVec(24'h987000, 6'h00, 6'h00, 1'b1, 2'd3, 2, 0, 6'h3B, 7'h40, 1'b1);
        addVec(24'h987000, 6'h00, 6'h00, 1'b1, 2'd3, 3, 0, 6'h37, 7'h78, 1'b1);
        addVec(24'h987000, 6'h00, 6'h00, 1'b1, 2'd3, 4, 0, 6'h2F, 7'h00, 1'b1);
        addVec(24'h987000, 6'h00, 6'h00, 1'b1, 2'd3, 5, 0, 6'h1F, 7'h10, 1'b1);
        addVec(24'h00D000, 6'h00, 6'h00, 1'b1, 2'd3, 3, 0, 6'h37, 7'h21, 1'b1);
        // blank and decimal point, glyphs A..F
        addVec(24'hABCDEF, 6'h02, 6'h04, 1'b0, 2'd3, 2, 0, 6'h3F, 7'h7F, 1'b1);
        addVec(24'hABCDEF, 6'h02, 6'h04, 1'b0, 2'd3, 1, 0, 6'h3D, 7'h06, 1'b0);
        addVec(24'hABCDEF, 6'h02, 6'h04, 1'b0, 2'd3, 0, 0, 6'h3E, 7'h0E, 1'b1);
        addVec(24'hABCDEF, 6'h02, 6'h04, 1'b0, 2'd3, 3, 0, 6'h37, 7'h46, 1'b1);
        addVec(24'hABCDEF, 6'h02, 6'h04, 1'b0, 2'd3, 4, 0, 6'h2F, 7'h03, 1'b1);
        addVec(24'hABCDEF, 6'h02, 6'h04, 1'b0, 2'd3, 5, 0, 6'h1F, 7'h08, 1'b1);
        addVec(24'hABCDEF, 6'h02, 6'h04, 1'b0, 2'd0, 1, 2, 6'h3D, 7'h06, 1'b0);
        addVec(24'hABCDEF, 6'h02, 6'h04, 1'b0, 2'd0, 1, 5, 6'h3F, 7'h7F, 1'b1);
        // PWM duty edges
        addVec(24'h123456, 6'h00, 6'h00, 1'b0, 2'd0, 0, 3, 6'h3E, 7'h02, 1'b1);
        addVec(24'h123456, 6'h00, 6'h00, 1'b0, 2'd0, 0, 4, 6'h3F, 7'h7F, 1'b1);
        addVec(24'h123456, 6'h00, 6'h00, 1'b0, 2'd2, 0, 11, 6'h3E, 7'h02, 1'b1);
        addVec(24'h123456, 6'h00, 6'h00, 1'b0, 2'd2, 0, 12, 6'h3F, 7'h7F, 1'b1);
        addVec(24'h123456, 6'h00, 6'h00, 1'b0, 2'd1, 5, 7, 6'h1F, 7'h79, 1'b1);
        addVec(24'h123456, 6'h00, 6'h00, 1'b0, 2'd1, 5, 8, 6'h3F, 7'h7F, 1'b1);

        // ---------------- reset state ----------------
        applyStimulus(24'h000000, 6'h00, 6'h00, 1'b0, 2'd3);
        clr_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_an", 32'(an), 32'h3F);
        checkOutput("reset_out", 32'(out), 32'h7F);
        checkOutput("reset_dp", 32'(dp), 32'h1);
        checkOutput("reset_frame_start", 32'(frame_start), 32'h0);

        // ---------------- first frame after release ----------------
        clr_n  = 1'b1;
        chk_en = 1'b1;
        saw_lit = 1'b0;
        ok = 1'b0;
        cyc = 0;
        for (int i = 0; i < 3 * FRAME_CLKS; i++) begin
            @(negedge clk);
            cyc++;
            if (frame_start) begin
                ok = 1'b1;
                break;
            end
            if (an != 6'h3F) saw_lit = 1'b1;
        end
        checkOutput("first_frame_seen", 32'(ok), 32'h1);
        checkOutput("first_frame_clks", 32'(cyc), 32'(FRAME_CLKS));
        checkOutput("dark_before_first_frame", 32'(saw_lit), 32'h0);
        waitFrame(cyc, ok);
        checkOutput("frame_period", 32'(cyc), 32'(FRAME_CLKS));

        // ---------------- vector table ----------------
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].nibs, vecs[i].dps, vecs[i].blanks, vecs[i].lz, vecs[i].br);
            waitFrame(cyc, ok);
            checkOutput("vec_frame_seen", 32'(ok), 32'h1);
            gotoSlot(vecs[i].slot, vecs[i].cnt);
            checkOutput($sformatf("vec%0d_an", i), 32'(an), 32'(vecs[i].e_an));
            checkOutput($sformatf("vec%0d_out", i), 32'(out), 32'(vecs[i].e_out));
            checkOutput($sformatf("vec%0d_dp", i), 32'(dp), 32'(vecs[i].e_dp));
        end

        // ---------------- mid-frame input change is not visible ----------------
        applyStimulus(24'h123456, 6'h00, 6'h00, 1'b0, 2'd3);
        waitFrame(cyc, ok);
        waitFrame(cyc, ok);
        checkOutput("snap_frame_seen", 32'(ok), 32'h1);
        gotoSlot(2, 0);
        in = 24'hABCDEF;
        repeat (2 * SLOT_CLKS) @(posedge clk);
        @(negedge clk);
        checkOutput("snap_old_an", 32'(an), 32'h2F);
        checkOutput("snap_old_out", 32'(out), 32'h24);
        waitFrame(cyc, ok);
        gotoSlot(4, 0);
        checkOutput("snap_new_an", 32'(an), 32'h2F);
        checkOutput("snap_new_out", 32'(out), 32'h03);

        // ---------------- reset in the middle of a lit slot ----------------
        applyStimulus(24'h123456, 6'h00, 6'h00, 1'b0, 2'd3);
        waitFrame(cyc, ok);
        waitFrame(cyc, ok);
        gotoSlot(1, 4);
        checkOutput("midreset_precond_an", 32'(an), 32'h3D);
        #2;
        clr_n = 1'b0;
        #1;
        checkOutput("midreset_an", 32'(an), 32'h3F);
        checkOutput("midreset_out", 32'(out), 32'h7F);
        checkOutput("midreset_dp", 32'(dp), 32'h1);
        checkOutput("midreset_frame_start", 32'(frame_start), 32'h0);
        repeat (2) @(negedge clk);
        clr_n = 1'b1;
        waitFrame(cyc, ok);
        checkOutput("midreset_first_frame_clks", 32'(cyc), 32'(FRAME_CLKS));

        // ---------------- randomized run against the model ----------------
        for (int r = 0; r < 60; r++) begin
            repeat ($urandom_range(5, 80)) @(negedge clk);
            in     = 24'($urandom) >> (4 * $urandom_range(0, 6));
            dp_in  = 6'($urandom);
            blank  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h00;
            lz_en  = 1'($urandom);
            bright = 2'($urandom);
        end
        repeat (2 * FRAME_CLKS) @(negedge clk);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
